// File: rtl/power_emulator_host.sv
// power_emulator_host: host-side bus sequencer for the power emulator slave.
// Runs start/wait/fin, reads both result words, clears control, returns 64 bits.
module power_emulator_host #(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_cycles,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic             busy,
    output logic             m_read,
    output logic             m_write,
    output logic [1:0]       m_addr,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_START = 4'd1;
    localparam logic [3:0] S_WAIT     = 4'd2;
    localparam logic [3:0] S_WR_FIN   = 4'd3;
    localparam logic [3:0] S_RD_HI    = 4'd4;
    localparam logic [3:0] S_WAIT_HI  = 4'd5;
    localparam logic [3:0] S_RD_LO    = 4'd6;
    localparam logic [3:0] S_WAIT_LO  = 4'd7;
    localparam logic [3:0] S_WR_CLR   = 4'd8;
    localparam logic [3:0] S_RESP     = 4'd9;

    logic [3:0]       state;
    logic [3:0]       state_nx;
    logic [CNT_W-1:0] run_cnt;
    logic [LAT_W-1:0] lat_cnt;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_RESP);

    // Next-state sequencing through the fixed command script.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (cmd_valid) state_nx = S_WR_START;
            S_WR_START: state_nx = (run_cnt == '0) ? S_WR_FIN : S_WAIT;
            S_WAIT:     if (run_cnt <= CNT_W'(1)) state_nx = S_WR_FIN;
            S_WR_FIN:   state_nx = S_RD_HI;
            S_RD_HI:    state_nx = S_WAIT_HI;
            S_WAIT_HI:  if (lat_cnt == '0) state_nx = S_RD_LO;
            S_RD_LO:    state_nx = S_WAIT_LO;
            S_WAIT_LO:  if (lat_cnt == '0) state_nx = S_WR_CLR;
            S_WR_CLR:   state_nx = S_RESP;
            S_RESP:     if (res_ready) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Bus strobes decoded from state so reset drops them immediately.
    always_comb begin
        m_read  = 1'b0;
        m_write = 1'b0;
        m_addr  = 2'd0;
        m_wdata = 32'd0;
        case (state)
            S_WR_START: begin
                m_write = 1'b1;
                m_wdata = 32'h1;
            end
            S_WR_FIN: begin
                m_write = 1'b1;
                m_wdata = 32'h3;
            end
            S_RD_HI: begin
                m_read = 1'b1;
                m_addr = 2'd2;
            end
            S_RD_LO: begin
                m_read = 1'b1;
                m_addr = 2'd3;
            end
            S_WR_CLR: m_write = 1'b1;
            default: ;
        endcase
    end

    // State, run/latency counters and result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            run_cnt  <= '0;
            lat_cnt  <= '0;
            res_data <= 64'd0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && cmd_valid)
                run_cnt <= cmd_cycles;
            else if (state == S_WAIT && run_cnt != '0)
                run_cnt <= run_cnt - CNT_W'(1);
            if (state == S_RD_HI || state == S_RD_LO)
                lat_cnt <= LAT_LOAD;
            else if ((state == S_WAIT_HI || state == S_WAIT_LO) && lat_cnt != '0)
                lat_cnt <= lat_cnt - LAT_W'(1);
            if (state == S_WAIT_HI && lat_cnt == '0)
                res_data[63:32] <= m_rdata;
            if (state == S_WAIT_LO && lat_cnt == '0)
                res_data[31:0] <= m_rdata;
        end
    end

endmodule

// File: doc/power_emulator_host.md
# power_emulator_host

Bus-initiator sequencer that drives the power emulator's 4-word register slave from the host side. On each accepted command it writes the start bit, lets the emulator run for a commanded number of cycles, writes the fin bit, reads back the two result words and clears the control word. It then presents the 64-bit result on a valid/ready output. It sits between the system controller and the slave's `s_*` port, with `m_*` wired one-to-one onto `s_*`.

## Interface
- `RD_LAT`, 1: slave read latency in cycles from the read-strobe cycle to the cycle `m_rdata` is valid (1 matches the registered slave).
- `CNT_W`, 16: width of the run-cycle count.
- `clk` in 1: single clock, all logic rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_cycles` in CNT_W: emulator run length N in cycles, captured at acceptance.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts result.
- `res_data` out 64: `{word2, word3}` read from the slave.
- `busy` out 1: high in every state except IDLE.
- `m_read` out 1: read strobe, one cycle per access.
- `m_write` out 1: write strobe, one cycle per access.
- `m_addr` out 2: word address.
- `m_wdata` out 32: write data.
- `m_rdata` in 32: read data from the slave.

## Operation
- States and order: IDLE → WR_START → WAIT → WR_FIN → RD_HI → WAIT_HI → RD_LO → WAIT_LO → WR_CLR → RESP → IDLE.
- IDLE
  - Accept on `cmd_valid && cmd_ready`.
  - Latch `cmd_cycles` into the run counter and go to WR_START.
- WR_START
  - Drive `m_write`=1, `m_addr`=0, `m_wdata`=32'h1.
  - Go to WAIT, or straight to WR_FIN if N=0.
- WAIT
  - Decrement the counter once per cycle.
  - Stay exactly N cycles, then go to WR_FIN.
- WR_FIN: drive `m_write`=1, `m_addr`=0, `m_wdata`=32'h3 (start and fin).
- RD_HI: drive `m_read`=1, `m_addr`=2.
- WAIT_HI
  - Stay RD_LAT cycles.
  - Capture `m_rdata` into `res_data[63:32]` on the edge that leaves this state.
- RD_LO / WAIT_LO: same as RD_HI / WAIT_HI with `m_addr`=3, capturing into `res_data[31:0]`.
- WR_CLR: drive `m_write`=1, `m_addr`=0, `m_wdata`=0.
- RESP
  - `res_valid`=1; `res_data` holds stable until `res_valid && res_ready`.
  - Then go to IDLE.
- Bus outputs outside strobe states: `m_read`=`m_write`=0, `m_addr`=0, `m_wdata`=0.
- `m_read` and `m_write` are never high together.
- Arithmetic: the run counter is CNT_W unsigned.
  - N=2^CNT_W−1 runs the full count with no wrap.
  - The counter never decrements below 0.
- `cmd_valid` outside IDLE is ignored and the command is not queued.
- `cmd_cycles` changes after acceptance are ignored.

## Timing
- Reset values (asynchronous, while `reset_n`=0)
  - State=IDLE, so `cmd_ready`=1 and `busy`=0.
  - `res_valid`=0, `res_data`=0, `m_read`=0, `m_write`=0, `m_addr`=0, `m_wdata`=0, counter=0.
- Reset asserted mid-sequence
  - All strobes drop immediately and the state returns to IDLE.
  - The slave's word 0 may retain 1 or 3; the next WR_START overwrites it.
- Latency
  - State is WR_START on the acceptance edge.
  - `res_valid` rises N+2·RD_LAT+5 edges after the acceptance edge (N+7 with RD_LAT=1).
- RESP handshake
  - The handshake edge returns to IDLE.
  - A new command is accepted no earlier than the following edge (minimum one IDLE cycle between commands).
- Back-pressure: `res_ready` held low keeps RESP indefinitely with no bus activity.

## Test plan
- Reset: hold `reset_n`=0 mid-WAIT with N=20 → all outputs at reset values within the same cycle, `cmd_ready`=1; release and run a command → normal completion.
- Basic run: N=5, slave model returns word2=32'h00000007, word3=32'hDEADBEEF → bus trace in this order:
  - write(0,1)
  - 5 idle cycles
  - write(0,3)
  - read(2)
  - read(3)
  - write(0,0)
  - `res_valid` 12 edges after acceptance, `res_data`=64'h00000007_DEADBEEF.
- N=0 → WR_FIN immediately follows WR_START; `res_valid` 7 edges after acceptance.
- Back-pressure: `res_ready`=0 for 10 cycles → `res_valid` stays 1, `res_data` stable, no strobes; raise `res_ready` → IDLE next edge.
- Command during busy: pulse `cmd_valid` in WAIT with different `cmd_cycles` → ignored, original N honoured, exactly one result produced.
- RD_LAT=3 build: slave model with 3-cycle latency returning word2=1, word3=2 → capture at the correct cycles, `res_data`=64'h00000001_00000002, `res_valid` at N+11.
